// File: rtl/sdio_clk_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdio_clk_gate_ctrl_if
//
// Purpose : Bundles the per-channel client signals of the SDIO clock-gating
//           controller. One bit per channel on every vector.
//
// Signals :
//   en_i        client -> ctrl   software enable per channel
//   busy_i      client -> ctrl   activity request per channel (clk_i domain)
//   clk_o       ctrl -> client   gated clocks
//   ready_o     ctrl -> client   registered; clock running, client may proceed
//   gated_o     ctrl -> client   registered; channel currently gated
//   gated_cnt_o ctrl -> client   per-channel gated-cycle counters, packed
//                                NUM_CH x STAT_W (only with CLK_GATE_STATS_EN)
//
// Modports:
//   master : the client side (drives en_i / busy_i)
//   slave  : the controller side
//
// Build option: define CLK_GATE_STATS_EN to add STAT_W and gated_cnt_o.
// ---------------------------------------------------------------------------
interface sdio_clk_gate_ctrl_if #(
  parameter int NUM_CH = 4
`ifdef CLK_GATE_STATS_EN
  , parameter int STAT_W = 16
`endif
);

  logic [NUM_CH-1:0] en_i;
  logic [NUM_CH-1:0] busy_i;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] ready_o;
  logic [NUM_CH-1:0] gated_o;

`ifdef CLK_GATE_STATS_EN
  logic [NUM_CH*STAT_W-1:0] gated_cnt_o;

  modport master (
    output en_i,
    output busy_i,
    input  clk_o,
    input  ready_o,
    input  gated_o,
    input  gated_cnt_o
  );

  modport slave (
    input  en_i,
    input  busy_i,
    output clk_o,
    output ready_o,
    output gated_o,
    output gated_cnt_o
  );
`else
  modport master (
    output en_i,
    output busy_i,
    input  clk_o,
    input  ready_o,
    input  gated_o
  );

  modport slave (
    input  en_i,
    input  busy_i,
    output clk_o,
    output ready_o,
    output gated_o
  );
`endif

endinterface

// File: rtl/sdio_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// sdio_clk_gate_ctrl
//
// Purpose : Multi-channel glitch-free clock-gating controller for the SDIO
//           host. Each channel owns a gated copy of clk_i that opens when the
//           client raises busy and closes after IDLE_CYCLES consecutive idle
//           cycles (or when software clears en with the client idle).
//
// Ports   :
//   clk_i       in   core clock, source of every gated clock
//   rst_ni      in   asynchronous active-low reset
//   test_en_i   in   scan/test bypass, forces every clk_o open (quasi-static)
//   bus         slave modport of sdio_clk_gate_ctrl_if:
//                 en_i, busy_i -> clk_o, ready_o, gated_o [, gated_cnt_o]
//
// Parameters:
//   NUM_CH      number of independent channels (1..16)
//   IDLE_W      width of the per-channel idle counter
//   IDLE_CYCLES idle cycles in RUN before auto-gating, 0 = never auto-gate
//   STAT_W      width of the gated-cycle counters (CLK_GATE_STATS_EN only)
//
// Build option: CLK_GATE_STATS_EN adds saturating per-channel counters of
//               cycles spent in GATED, exposed on gated_cnt_o.
//
// Per-channel flow: GATED -> OPEN (1 cycle) -> RUN -> GATED.
// ready_o/gated_o are registered copies of the state decode, so ready_o rises
// one cycle after the first full clk_o pulse.
// ---------------------------------------------------------------------------
module sdio_clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int IDLE_CYCLES = 16
`ifdef CLK_GATE_STATS_EN
  , parameter int STAT_W    = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  sdio_clk_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_GATED = 2'd0,
    ST_OPEN  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Terminal idle count; only meaningful when auto-gating is enabled.
  localparam int              IDLE_LIM_I = (IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0;
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_LIM_I);
  localparam bit              AUTO_GATE  = (IDLE_CYCLES != 0);

`ifdef CLK_GATE_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : (v + 1'b1);
  endfunction
`endif

  logic [NUM_CH-1:0] latch_d;
  logic [NUM_CH-1:0] en_latch;
  logic [NUM_CH-1:0] ready_p1;
  logic [NUM_CH-1:0] gated_p1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    state_e            state_q;
    state_e            state_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;

    // ---- stage p0: channel state and idle counter ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_GATED;
        idle_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
      end
    end

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      unique case (state_q)
        ST_GATED: begin
          idle_d = '0;
          // en_i low blocks the open even with busy_i high.
          if (bus.en_i[ch] && bus.busy_i[ch]) begin
            state_d = ST_OPEN;
          end
        end
        ST_OPEN: begin
          // Single cycle so the client sees a full clk_o pulse before ready.
          idle_d  = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.busy_i[ch]) begin
            // Busy always wins, also on the cycle the idle limit is reached.
            idle_d = '0;
          end else if (!bus.en_i[ch]) begin
            // Software disable only takes effect once the client is idle.
            state_d = ST_GATED;
            idle_d  = '0;
          end else if (AUTO_GATE) begin
            if (idle_q == IDLE_LIM) begin
              state_d = ST_GATED;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_GATED;
          idle_d  = '0;
        end
      endcase
    end

    assign latch_d[ch] = (state_q == ST_OPEN) || (state_q == ST_RUN);

    // ---- stage p1: registered status outputs ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ready_p1[ch] <= 1'b0;
        gated_p1[ch] <= 1'b1;
      end else begin
        ready_p1[ch] <= (state_q == ST_RUN);
        gated_p1[ch] <= (state_q == ST_GATED);
      end
    end

`ifdef CLK_GATE_STATS_EN
    logic [STAT_W-1:0] gated_cnt_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        gated_cnt_p1 <= '0;
      end else if (state_q == ST_GATED) begin
        gated_cnt_p1 <= sat_inc(gated_cnt_p1);
      end
    end

    assign bus.gated_cnt_o[ch*STAT_W +: STAT_W] = gated_cnt_p1;
`endif

  end

  // Enable latch, transparent while clk_i is low: the enable can only change
  // during the low phase, so the AND below never chops a high phase. The
  // asynchronous clear stops every gated clock as soon as reset asserts.
  always_latch begin
    if (!rst_ni) begin
      en_latch = '0;
    end else if (!clk_i) begin
      en_latch = latch_d;
    end
  end

  assign bus.clk_o   = {NUM_CH{clk_i}} & (en_latch | {NUM_CH{test_en_i}});
  assign bus.ready_o = ready_p1;
  assign bus.gated_o = gated_p1;

endmodule

// File: tb/tb_sdio_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdio_clk_gate_ctrl
//
// Directed stimulus pushes expected {ready_o, gated_o, clk_o} snapshots into
// a scoreboard queue tagged with the cycle they apply to; monitor processes
// sample the DUT 1 ns after each rising clk_i edge (clk_o high phase) or 1 ns
// after reset asserts, and pop/compare the matching entries.
// ---------------------------------------------------------------------------
module tb_sdio_clk_gate_ctrl;

  localparam int NUM_CH = 4;
`ifdef CLK_GATE_STATS_EN
  localparam int STAT_W = 4;
`endif

  logic clk_i     = 1'b0;
  logic rst_ni    = 1'b0;
  logic test_en_i = 1'b0;

`ifdef CLK_GATE_STATS_EN
  sdio_clk_gate_ctrl_if #(.NUM_CH(NUM_CH), .STAT_W(STAT_W)) bus ();
`else
  sdio_clk_gate_ctrl_if #(.NUM_CH(NUM_CH)) bus ();
`endif

  sdio_clk_gate_ctrl #(
    .NUM_CH      (NUM_CH),
    .IDLE_W      (8),
    .IDLE_CYCLES (16)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W    (STAT_W)
`endif
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .test_en_i (test_en_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         at_rst;
    string      name;
    logic [3:0] mask;
    logic [3:0] rdy;
    logic [3:0] gtd;
    logic [3:0] clk;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  function automatic void push(input int off, input string nm, input logic [3:0] m,
                               input logic [3:0] r, input logic [3:0] g, input logic [3:0] c);
    exp_t e;
    e.cyc = cyc + off; e.at_rst = 1'b0; e.name = nm;
    e.mask = m; e.rdy = r; e.gtd = g; e.clk = c;
    sb.push_back(e);
  endfunction

  function automatic void push_rst(input string nm, input logic [3:0] m,
                                   input logic [3:0] r, input logic [3:0] g, input logic [3:0] c);
    exp_t e;
    e.cyc = cyc; e.at_rst = 1'b1; e.name = nm;
    e.mask = m; e.rdy = r; e.gtd = g; e.clk = c;
    sb.push_back(e);
  endfunction

  task automatic compare(input exp_t e);
    logic [3:0] ar, ag, ac;
    ar = bus.ready_o; ag = bus.gated_o; ac = bus.clk_o;
    chk_cnt++;
    if (((ar & e.mask) === (e.rdy & e.mask)) &&
        ((ag & e.mask) === (e.gtd & e.mask)) &&
        ((ac & e.mask) === (e.clk & e.mask))) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s @cyc %0d mask=%h: ready_o=%h want %h, gated_o=%h want %h, clk_o=%h want %h",
               e.name, cyc, e.mask, ar & e.mask, e.rdy & e.mask, ag & e.mask,
               e.gtd & e.mask, ac & e.mask, e.clk & e.mask);
    end
  endtask

  // Edge monitor: samples in the high phase after each rising edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!sb[i].at_rst && sb[i].cyc == cyc) begin
          compare(sb[i]);
          sb.delete(i);
        end else if (!sb[i].at_rst && sb[i].cyc < cyc) begin
          chk_cnt++;
          $display("FAIL %s: never sampled, wanted at cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
          sb.delete(i);
        end
      end
    end
  end

  // Reset monitor: samples just after reset asserts, before any clock edge.
  initial begin
    forever begin
      @(negedge rst_ni);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at_rst) begin
          compare(sb[i]);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run still active at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.en_i   = '0;
    bus.busy_i = '0;

    // Reset held.
    @(negedge clk_i);
    push(1, "reset_state", 4'hF, 4'h0, 4'hF, 4'h0);
    tick(2);

    // Reset release, all enabled, nobody busy: everything stays gated.
    rst_ni   = 1'b1;
    bus.en_i = 4'hF;
    push(1,  "idle_c1",  4'hF, 4'h0, 4'hF, 4'h0);
    push(10, "idle_c10", 4'hF, 4'h0, 4'hF, 4'h0);
    push(20, "idle_c20", 4'hF, 4'h0, 4'hF, 4'h0);
    tick(20);

`ifdef CLK_GATE_STATS_EN
    chk_cnt++;
    if (bus.gated_cnt_o === {NUM_CH{4'hF}}) pass_cnt++;
    else $display("FAIL stats_saturate: gated_cnt_o=%h want %h", bus.gated_cnt_o, {NUM_CH{4'hF}});
`endif

    // ch0 open: clk_o pulse one edge after busy is sampled, ready one later.
    bus.busy_i[0] = 1'b1;
    push(1, "ch0_open_wait",   4'h1, 4'h0, 4'h1, 4'h0);
    push(2, "ch0_first_pulse", 4'h1, 4'h0, 4'h0, 4'h1);
    push(3, "ch0_ready",       4'h1, 4'h1, 4'h0, 4'h1);
    push(3, "others_gated",    4'hE, 4'h0, 4'hE, 4'h0);
    tick(4);

    // ch1 auto-gates after 16 idle cycles.
    bus.busy_i[1] = 1'b1;
    tick(4);
    bus.busy_i[1] = 1'b0;
    push(15, "ch1_idle_15",    4'h2, 4'h2, 4'h0, 4'h2);
    push(16, "ch1_last_pulse", 4'h2, 4'h2, 4'h0, 4'h2);
    push(17, "ch1_auto_gated", 4'h2, 4'h0, 4'h2, 4'h0);
    tick(20);

    // ch1 again, busy pulsed when the idle count sits at 15: count restarts.
    bus.busy_i[1] = 1'b1;
    tick(4);
    bus.busy_i[1] = 1'b0;
    push(17, "ch1_busy_wins",    4'h2, 4'h2, 4'h0, 4'h2);
    push(32, "ch1_restart_last", 4'h2, 4'h2, 4'h0, 4'h2);
    push(33, "ch1_restart_gate", 4'h2, 4'h0, 4'h2, 4'h0);
    tick(15);
    bus.busy_i[1] = 1'b1;
    tick(1);
    bus.busy_i[1] = 1'b0;
    tick(20);

    // ch2: en cleared while busy keeps running; gates right after busy drops.
    bus.busy_i[2] = 1'b1;
    tick(4);
    bus.en_i[2] = 1'b0;
    push(3, "ch2_en_low_runs",  4'h4, 4'h4, 4'h0, 4'h4);
    push(6, "ch2_last_pulse",   4'h4, 4'h4, 4'h0, 4'h4);
    push(7, "ch2_gated_en_low", 4'h4, 4'h0, 4'h4, 4'h0);
    tick(5);
    bus.busy_i[2] = 1'b0;
    tick(5);
    bus.en_i[2] = 1'b1;

    // Close ch0, then test bypass with every channel gated.
    bus.busy_i  = '0;
    bus.en_i[0] = 1'b0;
    push(2, "all_gated", 4'hF, 4'h0, 4'hF, 4'h0);
    tick(3);
    bus.en_i  = 4'hF;
    test_en_i = 1'b1;
    push(1, "test_clk_open_a", 4'hF, 4'h0, 4'hF, 4'hF);
    push(2, "test_clk_open_b", 4'hF, 4'h0, 4'hF, 4'hF);
    tick(2);
    test_en_i = 1'b0;
    push(1, "test_off", 4'hF, 4'h0, 4'hF, 4'h0);
    tick(2);

    // Reset asserted mid-RUN on ch0, in the clk_i high phase.
    bus.busy_i[0] = 1'b1;
    tick(4);
    push(1, "ch0_before_rst", 4'h1, 4'h1, 4'h0, 4'h1);
    @(posedge clk_i);
    #3;
    push_rst("rst_async_stop", 4'hF, 4'h0, 4'hF, 4'h0);
    rst_ni = 1'b0;
    tick(2);
    rst_ni     = 1'b1;
    bus.busy_i = '0;
    tick(3);

    for (int i = 0; i < sb.size(); i++) begin
      chk_cnt++;
      $display("FAIL %s: never sampled, wanted at cyc %0d", sb[i].name, sb[i].cyc);
    end
    sb.delete();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sdio_clk_gate_ctrl.md
Name: sdio_clk_gate_ctrl

Overview:
- Multi-channel, glitch-free clock-gating controller for the SDIO host.
- Each channel owns a gated copy of the core clock. The copy opens on demand when a client raises busy, and auto-closes after a programmable idle window.
- Provides a per-channel ready handshake and a scan/test bypass.
- Sits between the core clock and the per-function SDIO sub-blocks (CMD engine, DAT engine, FIFO, etc.).

Parameters:
- NUM_CH, 4: number of independent gated clock channels (1..16).
- IDLE_W, 8: width of the per-channel idle counter.
- IDLE_CYCLES, 16: consecutive non-busy cycles in RUN before auto-gating. 0 disables auto-gating. Must be < 2^IDLE_W.
- STAT_W, 16: width of the gated-cycle statistics counters (optional feature only).

Ports:
- clk_i  in  1  core clock; source of all gated clocks.
- rst_ni  in  1  asynchronous active-low reset.
- test_en_i  in  1  scan/test bypass; forces every clk_o open; quasi-static.
- en_i  in  NUM_CH  per-channel software enable; 0 = channel may not run.
- busy_i  in  NUM_CH  per-channel activity request from the client, synchronous to clk_i.
- clk_o  out  NUM_CH  gated clocks.
- ready_o  out  NUM_CH  registered; 1 = clock running, client may proceed.
- gated_o  out  NUM_CH  registered; 1 = channel currently gated (status/CSR).
- gated_cnt_o  out  NUM_CH*STAT_W  per-channel gated-cycle count; present only with CLK_GATE_STATS_EN.

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low via rst_ni: asserting it immediately forces all state as below, independent of clk_i.
- Reset values:
  - state = GATED
  - ready_o = 0
  - gated_o = all ones
  - idle counter = 0
  - enable latch = 0
  - clk_o = 0 unless test_en_i = 1
  - gated_cnt_o = 0
- Per-channel FSM, updated on posedge clk_i:
  - GATED:
    - en_i & busy_i -> OPEN.
    - Otherwise stay. ready_o = 0, gated_o = 1.
  - OPEN (exactly 1 cycle):
    - Unconditionally -> RUN. ready_o = 0, gated_o = 0.
    - Purpose: guarantees at least one full clk_o pulse before ready_o rises.
  - RUN: ready_o = 1, gated_o = 0.
    - busy_i = 1: idle counter cleared to 0; stay.
    - busy_i = 0 & en_i = 0: -> GATED next cycle; an active transfer is never truncated by en_i falling.
    - busy_i = 0 & en_i = 1 & IDLE_CYCLES != 0: counter increments.
      - If counter == IDLE_CYCLES-1 -> GATED, counter cleared.
    - IDLE_CYCLES == 0: never auto-gates; leaves RUN only via en_i = 0 with busy_i = 0.
- Latency:
  - busy_i rise at cycle N (from GATED) -> first clk_o rising edge at N+1.
  - ready_o high at N+2.
  - Gating decision at edge M -> last clk_o high phase is in cycle M; clk_o low from M+1.
- Glitch-free gating:
  - The enable latch is transparent while clk_i is low. Its D input is (state == OPEN || state == RUN).
  - clk_o = clk_i & (en_latch | test_en_i).
  - No combinational path from busy_i or en_i to clk_o.
- test_en_i:
  - Overrides gating for clk_o only.
  - FSM, ready_o and gated_o behave normally.
- Simultaneous events:
  - busy_i re-asserted in the same cycle the counter hits the limit: busy wins; stay in RUN, counter cleared.
  - en_i = 0 and busy_i = 1 in GATED: no open.
- Reset mid-RUN: clk_o stops asynchronously and ready_o drops; the client must treat this as an abort.
- Channels are fully independent; no shared arbitration.

Optional Feature:
- Macro: CLK_GATE_STATS_EN.
- Defined:
  - Per-channel counter increments on every posedge clk_i while the channel is in GATED, and saturates at 2^STAT_W-1.
  - Cleared by reset only.
  - Exposed on gated_cnt_o.
- Undefined: gated_cnt_o port and counters are absent; no other behavioural change.

Test Plan:
- Reset release, en_i = 0xF, busy_i = 0 for 20 cycles -> clk_o all flat 0, gated_o = 0xF, ready_o = 0.
- ch0: busy_i[0] rises at cycle 10 -> first clk_o[0] edge at cycle 11, ready_o[0] = 1 at cycle 12; other channels stay gated.
- ch1 in RUN, busy_i[1] drops, IDLE_CYCLES = 16 -> ready_o[1] falls and clk_o[1] stops exactly 16 cycles later. Repeat with busy_i pulsed at idle count 15 -> channel stays in RUN, counter restarts.
- ch2 in RUN with busy_i = 1, en_i[2] cleared -> clock continues. busy_i dropped 5 cycles later -> gated on the next cycle.
- test_en_i = 1 with all channels GATED -> every clk_o toggles with clk_i; gated_o still 0xF.
- Reset asserted mid-RUN on ch0 -> clk_o[0] low and ready_o[0] = 0 immediately, before the next clk_i edge. With CLK_GATE_STATS_EN, STAT_W = 4: 20 gated cycles -> gated_cnt_o[ch] = 15, saturated.
